// File: rtl/pipe_stage_elastic.sv
// Elastic pipeline register for one stage boundary.
// Carries an opaque control bundle and data bundle behind a valid/ready
// handshake, with a two-entry skid buffer so the upstream ready never
// depends combinationally on the downstream ready. The stage also supports
// freeze (stall from the hazard unit), flush (kill from the branch unit) and
// a saturating counter of the valid entries that flushes discarded.
module pipe_stage_elastic #(
  parameter int CTRL_W   = 8,
  parameter int DATA_W   = 64,
  parameter int CLR_DATA = 0,
  parameter int CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  input  logic              freeze,
  input  logic              flush,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  kill_cnt
);

  // The state encoding doubles as the entry count.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] CNT_SAT = '1;

  state_e            state_q, state_d;
  logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
  logic [DATA_W-1:0] main_data_q, main_data_d;
  logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
  logic [DATA_W-1:0] skid_data_q, skid_data_d;
  logic [CNT_W-1:0]  kill_cnt_q, kill_cnt_d;
  logic [CNT_W:0]    kill_sum;
  logic              acc;
  logic              con;

  // Handshake decode: accept only with a free skid slot and no stall or kill.
  always_comb begin
    out_valid = (state_q != ST_EMPTY);
    in_ready  = (state_q != ST_FULL) & ~freeze & ~flush;
    acc       = in_valid & in_ready;
    con       = out_valid & out_ready & ~freeze;
    occupancy = state_q;
    out_ctrl  = main_ctrl_q;
    out_data  = main_data_q;
    kill_cnt  = kill_cnt_q;
  end

  // Next-state logic; flush overrides the handshake and freeze.
  always_comb begin
    state_d     = state_q;
    main_ctrl_d = main_ctrl_q;
    main_data_d = main_data_q;
    skid_ctrl_d = skid_ctrl_q;
    skid_data_d = skid_data_q;
    kill_cnt_d  = kill_cnt_q;
    kill_sum    = {1'b0, kill_cnt_q} + (CNT_W+1)'(occupancy);
    if (flush) begin
      state_d     = ST_EMPTY;
      main_ctrl_d = '0;
      if (CLR_DATA != 0) begin
        main_data_d = '0;
      end
      if (kill_sum > {1'b0, CNT_SAT}) begin
        kill_cnt_d = CNT_SAT;
      end else begin
        kill_cnt_d = kill_sum[CNT_W-1:0];
      end
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (acc) begin
            state_d     = ST_ONE;
            main_ctrl_d = in_ctrl;
            main_data_d = in_data;
          end
        end
        ST_ONE: begin
          if (acc && con) begin
            main_ctrl_d = in_ctrl;
            main_data_d = in_data;
          end else if (acc) begin
            state_d     = ST_FULL;
            skid_ctrl_d = in_ctrl;
            skid_data_d = in_data;
          end else if (con) begin
            state_d = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (con) begin
            state_d     = ST_ONE;
            main_ctrl_d = skid_ctrl_q;
            main_data_d = skid_data_q;
          end
        end
        default: begin
          state_d = ST_EMPTY;
        end
      endcase
    end
  end

  // State registers; reset drops every held entry immediately.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_EMPTY;
      main_ctrl_q <= '0;
      main_data_q <= '0;
      skid_ctrl_q <= '0;
      skid_data_q <= '0;
      kill_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      main_ctrl_q <= main_ctrl_d;
      main_data_q <= main_data_d;
      skid_ctrl_q <= skid_ctrl_d;
      skid_data_q <= skid_data_d;
      kill_cnt_q  <= kill_cnt_d;
    end
  end

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Directed bench for pipe_stage_elastic: a default instance plus two
// CNT_W=2 instances (data held / data cleared on flush) share one stimulus.
module tb_pipe_stage_elastic;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [7:0]  in_ctrl;
  logic [63:0] in_data;
  logic        out_ready;
  logic        freeze;
  logic        flush;

  logic        in_ready, out_valid;
  logic [7:0]  out_ctrl;
  logic [63:0] out_data;
  logic [1:0]  occupancy;
  logic [15:0] kill_cnt;

  logic        s_in_ready, s_out_valid;
  logic [7:0]  s_out_ctrl;
  logic [63:0] s_out_data;
  logic [1:0]  s_occupancy;
  logic [1:0]  s_kill_cnt;

  logic        c_in_ready, c_out_valid;
  logic [7:0]  c_out_ctrl;
  logic [63:0] c_out_data;
  logic [1:0]  c_occupancy;
  logic [1:0]  c_kill_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  pipe_stage_elastic dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_ctrl(out_ctrl), .out_data(out_data),
    .freeze(freeze), .flush(flush), .occupancy(occupancy), .kill_cnt(kill_cnt)
  );

  pipe_stage_elastic #(.CTRL_W(8), .DATA_W(64), .CLR_DATA(0), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s_in_ready),
    .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(s_out_valid),
    .out_ready(out_ready), .out_ctrl(s_out_ctrl), .out_data(s_out_data),
    .freeze(freeze), .flush(flush), .occupancy(s_occupancy), .kill_cnt(s_kill_cnt)
  );

  pipe_stage_elastic #(.CTRL_W(8), .DATA_W(64), .CLR_DATA(1), .CNT_W(2)) dut_clr (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(c_in_ready),
    .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(c_out_valid),
    .out_ready(out_ready), .out_ctrl(c_out_ctrl), .out_data(c_out_data),
    .freeze(freeze), .flush(flush), .occupancy(c_occupancy), .kill_cnt(c_kill_cnt)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [7:0] c, input logic [63:0] d,
                       input logic ordy, input logic frz, input logic fl);
    in_valid  = v;
    in_ctrl   = c;
    in_data   = d;
    out_ready = ordy;
    freeze    = frz;
    flush     = fl;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    drive(1'b0, 8'h0, 64'h0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      drive(1'($urandom), 8'($urandom), {$urandom, $urandom}, 1'($urandom),
            1'($urandom), 1'($urandom));
      step();
      n_checks++;
      if (out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_valid got %0b expected 0", out_valid); end
      n_checks++;
      if (occupancy !== 2'd0) begin n_fail++; $display("[TB] FAIL reset_occ got %0d expected 0", occupancy); end
      n_checks++;
      if (kill_cnt !== 16'd0) begin n_fail++; $display("[TB] FAIL reset_kill got %0d expected 0", kill_cnt); end
      n_checks++;
      if (out_ctrl !== 8'h0 || out_data !== 64'h0) begin
        n_fail++; $display("[TB] FAIL reset_bundle got %0h/%0h expected 0/0", out_ctrl, out_data);
      end
    end
    drive(1'b0, 8'h0, 64'h0, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    step();
    n_checks++;
    if (out_valid !== 1'b0 || occupancy !== 2'd0) begin
      n_fail++; $display("[TB] FAIL reset_release got v=%0b occ=%0d expected v=0 occ=0", out_valid, occupancy);
    end
  endtask

  task automatic test_stream();
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 8'(i + 1), 64'(i), 1'b1, 1'b0, 1'b0);
      #1;
      n_checks++;
      if (in_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL stream_in_ready beat %0d got %0b expected 1", i, in_ready); end
      step();
      n_checks++;
      if (out_valid !== 1'b1 || out_data !== 64'(i) || out_ctrl !== 8'(i + 1)) begin
        n_fail++;
        $display("[TB] FAIL stream_out beat %0d got v=%0b d=%0h c=%0h expected v=1 d=%0h c=%0h",
                 i, out_valid, out_data, out_ctrl, i, i + 1);
      end
    end
    drive(1'b0, 8'h0, 64'h0, 1'b1, 1'b0, 1'b0);
    step();
    n_checks++;
    if (out_valid !== 1'b0 || occupancy !== 2'd0 || out_data !== 64'd9) begin
      n_fail++; $display("[TB] FAIL stream_drain got v=%0b occ=%0d d=%0h expected v=0 occ=0 d=9",
                         out_valid, occupancy, out_data);
    end
  endtask

  task automatic test_backpressure();
    drive(1'b1, 8'hA1, 64'h11, 1'b0, 1'b0, 1'b0);
    step();
    drive(1'b1, 8'hA2, 64'h22, 1'b0, 1'b0, 1'b0);
    step();
    drive(1'b0, 8'h0, 64'h0, 1'b0, 1'b0, 1'b0);
    #1;
    n_checks++;
    if (occupancy !== 2'd2 || in_ready !== 1'b0) begin
      n_fail++; $display("[TB] FAIL bp_full got occ=%0d rdy=%0b expected occ=2 rdy=0", occupancy, in_ready);
    end
    n_checks++;
    if (out_data !== 64'h11 || out_ctrl !== 8'hA1) begin
      n_fail++; $display("[TB] FAIL bp_head got %0h/%0h expected 11/a1", out_data, out_ctrl);
    end
    out_ready = 1'b1;
    step();
    n_checks++;
    if (out_valid !== 1'b1 || out_data !== 64'h22 || out_ctrl !== 8'hA2 || occupancy !== 2'd1) begin
      n_fail++; $display("[TB] FAIL bp_second got v=%0b d=%0h c=%0h occ=%0d expected v=1 d=22 c=a2 occ=1",
                         out_valid, out_data, out_ctrl, occupancy);
    end
    step();
    n_checks++;
    if (out_valid !== 1'b0 || occupancy !== 2'd0) begin
      n_fail++; $display("[TB] FAIL bp_empty got v=%0b occ=%0d expected v=0 occ=0", out_valid, occupancy);
    end
  endtask

  task automatic test_freeze();
    drive(1'b1, 8'hC3, 64'h33, 1'b0, 1'b0, 1'b0);
    step();
    drive(1'b1, 8'hC4, 64'h44, 1'b0, 1'b0, 1'b0);
    step();
    drive(1'b1, 8'hC5, 64'h55, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      #1;
      n_checks++;
      if (in_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL frz_in_ready got %0b expected 0", in_ready); end
      step();
      n_checks++;
      if (out_valid !== 1'b1 || out_data !== 64'h33 || out_ctrl !== 8'hC3 || occupancy !== 2'd2) begin
        n_fail++; $display("[TB] FAIL frz_hold cyc %0d got v=%0b d=%0h c=%0h occ=%0d expected v=1 d=33 c=c3 occ=2",
                           i, out_valid, out_data, out_ctrl, occupancy);
      end
    end
    drive(1'b0, 8'h0, 64'h0, 1'b1, 1'b0, 1'b0);
    step();
    n_checks++;
    if (out_data !== 64'h44 || out_ctrl !== 8'hC4 || occupancy !== 2'd1) begin
      n_fail++; $display("[TB] FAIL frz_drain got d=%0h c=%0h occ=%0d expected d=44 c=c4 occ=1",
                         out_data, out_ctrl, occupancy);
    end
    step();
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL frz_empty got %0b expected 0", out_valid); end
  endtask

  task automatic test_flush();
    drive(1'b1, 8'hE6, 64'h66, 1'b0, 1'b0, 1'b0);
    step();
    drive(1'b1, 8'hE7, 64'h77, 1'b0, 1'b0, 1'b0);
    step();
    drive(1'b1, 8'hE8, 64'h88, 1'b0, 1'b0, 1'b1);
    #1;
    n_checks++;
    if (in_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL fl_in_ready got %0b expected 0", in_ready); end
    step();
    n_checks++;
    if (out_valid !== 1'b0 || out_ctrl !== 8'h0 || occupancy !== 2'd0) begin
      n_fail++; $display("[TB] FAIL fl_state got v=%0b c=%0h occ=%0d expected v=0 c=0 occ=0",
                         out_valid, out_ctrl, occupancy);
    end
    n_checks++;
    if (kill_cnt !== 16'd2 || s_kill_cnt !== 2'd2 || c_kill_cnt !== 2'd2) begin
      n_fail++; $display("[TB] FAIL fl_kill got %0d/%0d/%0d expected 2/2/2", kill_cnt, s_kill_cnt, c_kill_cnt);
    end
    n_checks++;
    if (out_data !== 64'h66 || c_out_data !== 64'h0) begin
      n_fail++; $display("[TB] FAIL fl_data got %0h/%0h expected 66/0", out_data, c_out_data);
    end
    drive(1'b0, 8'h0, 64'h0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      step();
      n_checks++;
      if (out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL fl_no_ghost cyc %0d got v=%0b d=%0h expected v=0", i, out_valid, out_data); end
    end
  endtask

  task automatic test_kill_saturate();
    rst = 1'b0;
    #2;
    rst = 1'b1;
    step();
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 8'(8'h10 + k), 64'(64'h90 + k), 1'b0, 1'b0, 1'b0);
      step();
      drive(1'b0, 8'h0, 64'h0, 1'b1, (k == 2), 1'b1);
      step();
      n_checks++;
      if (kill_cnt !== 16'(k + 1)) begin
        n_fail++; $display("[TB] FAIL sat_kill16 flush %0d got %0d expected %0d", k, kill_cnt, k + 1);
      end
      n_checks++;
      if (s_kill_cnt !== ((k < 2) ? 2'(k + 1) : 2'd3) || c_kill_cnt !== s_kill_cnt) begin
        n_fail++; $display("[TB] FAIL sat_kill2 flush %0d got %0d/%0d expected %0d", k, s_kill_cnt, c_kill_cnt,
                           (k < 2) ? k + 1 : 3);
      end
      n_checks++;
      if (c_out_data !== 64'h0 || s_out_data !== 64'(64'h90 + k) || s_out_ctrl !== 8'h0 || s_out_valid !== 1'b0) begin
        n_fail++; $display("[TB] FAIL sat_data flush %0d got clr=%0h hold=%0h c=%0h v=%0b expected 0/%0h/0/0",
                           k, c_out_data, s_out_data, s_out_ctrl, s_out_valid, 64'h90 + k);
      end
      drive(1'b0, 8'h0, 64'h0, 1'b0, 1'b0, 1'b0);
    end
  endtask

  task automatic test_mid_reset();
    drive(1'b1, 8'hF1, 64'hF1, 1'b0, 1'b0, 1'b0);
    step();
    drive(1'b1, 8'hF2, 64'hF2, 1'b0, 1'b0, 1'b0);
    step();
    drive(1'b0, 8'h0, 64'h0, 1'b0, 1'b0, 1'b0);
    #2;
    rst = 1'b0;
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || occupancy !== 2'd0 || kill_cnt !== 16'd0 || out_data !== 64'h0) begin
      n_fail++; $display("[TB] FAIL mid_reset got v=%0b occ=%0d kill=%0d d=%0h expected 0/0/0/0",
                         out_valid, occupancy, kill_cnt, out_data);
    end
    rst = 1'b1;
    out_ready = 1'b1;
    step();
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL mid_reset_after got %0b expected 0", out_valid); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_freeze();
    test_flush();
    test_kill_saturate();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
